// File: rtl/ecg_bitstream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecg_bitstream_packer_pkg
// Brief    : Shared types, default sizes and width helpers for the ECG packer
// Revision : 1.0 - initial release
// ============================================================================
package ecg_bitstream_packer_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int C_MAX_CHUNK = 50;
  localparam int C_OUT_WIDTH = 32;

  function automatic int size_width(input int max_chunk);
    return $clog2(max_chunk + 1);
  endfunction

  function automatic int fill_width(input int out_width, input int max_chunk);
    return $clog2(out_width + max_chunk + 1);
  endfunction

  function automatic int bits_width(input int out_width);
    return $clog2(out_width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecg_bitstream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : ecg_bitstream_packer_if
// Brief    : Chunk-in / word-out handshake bundle for the ECG bitstream packer
// Revision : 1.0 - initial release
// ============================================================================
interface ecg_bitstream_packer_if
  import ecg_bitstream_packer_pkg::*;
#(
  parameter int MAX_CHUNK = C_MAX_CHUNK,
  parameter int OUT_WIDTH = C_OUT_WIDTH
) ();

  localparam int SZW = size_width(MAX_CHUNK);
  localparam int OBW = bits_width(OUT_WIDTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [MAX_CHUNK-1:0] in_data;
  logic [SZW-1:0]       in_size;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [OBW-1:0]       out_bits;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_size, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bits, out_last
  );

  modport master (
    output in_valid, in_data, in_size, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bits, out_last
  );

endinterface
`default_nettype wire

// File: rtl/ecg_bitstream_packer_aligner.sv
`default_nettype none
// ============================================================================
// Module   : ecg_bit_aligner
// Brief    : Places a chunk directly after the filled MSBs of the accumulator
// Revision : 1.0 - initial release
// ============================================================================
module ecg_bit_aligner
  import ecg_bitstream_packer_pkg::*;
#(
  parameter int MAX_CHUNK = C_MAX_CHUNK,
  parameter int OUT_WIDTH = C_OUT_WIDTH,
  localparam int AW  = OUT_WIDTH + MAX_CHUNK,
  localparam int SZW = size_width(MAX_CHUNK),
  localparam int FW  = fill_width(OUT_WIDTH, MAX_CHUNK)
) (
  input  wire logic [AW-1:0]        acc,
  input  wire logic [FW-1:0]        fill,
  input  wire logic [MAX_CHUNK-1:0] chunk,
  input  wire logic [SZW-1:0]       size,
  output logic      [AW-1:0]        acc_next,
  output logic      [FW-1:0]        fill_next
);

  localparam logic [FW-1:0] c_aw = FW'(AW);

  logic [FW-1:0] w_size_ext;
  logic [FW-1:0] w_shift;
  logic [AW-1:0] w_chunk_ext;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_placed;

  assign w_size_ext  = FW'(size);
  assign w_chunk_ext = {{OUT_WIDTH{1'b0}}, chunk};
  // A zero size shifts the all-ones mask out completely, appending nothing.
  assign w_mask      = {AW{1'b1}} >> (c_aw - w_size_ext);
  assign w_shift     = c_aw - fill - w_size_ext;
  assign w_placed    = (w_chunk_ext & w_mask) << w_shift;
  assign acc_next    = acc | w_placed;
  assign fill_next   = fill + w_size_ext;

endmodule
`default_nettype wire

// File: rtl/ecg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module   : ecg_bitstream_packer
// Brief    : Packs variable-size ECG chunks into MSB-first fixed-width words
// Revision : 1.0 - initial release
// ============================================================================
module ecg_bitstream_packer
  import ecg_bitstream_packer_pkg::*;
#(
  parameter int MAX_CHUNK = C_MAX_CHUNK,
  parameter int OUT_WIDTH = C_OUT_WIDTH
) (
  input  wire logic              clk,
  input  wire logic              rst,
  ecg_bitstream_packer_if.slave  bus,
  output logic                   err_oversize,
  output logic [7:0]             drop_count,
  output logic [15:0]            word_count
);

  localparam int AW  = OUT_WIDTH + MAX_CHUNK;
  localparam int SZW = size_width(MAX_CHUNK);
  localparam int FW  = fill_width(OUT_WIDTH, MAX_CHUNK);
  localparam int OBW = bits_width(OUT_WIDTH);

  localparam logic [FW-1:0]  c_ow_fill  = FW'(OUT_WIDTH);
  localparam logic [SZW-1:0] c_max_size = SZW'(MAX_CHUNK);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_acc, w_acc_nxt, w_app_acc;
  logic [FW-1:0]   r_fill, w_fill_nxt, w_app_fill;
  logic            r_err;
  logic [7:0]      r_drop;
  logic [15:0]     r_words;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_final;
  logic            w_accept;
  logic            w_xfer;
  logic            w_oversize;

  ecg_bit_aligner #(
    .MAX_CHUNK (MAX_CHUNK),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_aligner (
    .acc       (r_acc),
    .fill      (r_fill),
    .chunk     (bus.in_data),
    .size      (bus.in_size),
    .acc_next  (w_app_acc),
    .fill_next (w_app_fill)
  );

  // Ready and valid are mutually exclusive, so accept and transfer never coincide.
  assign w_in_ready  = (r_state == ST_ACCUM) && (r_fill < c_ow_fill);
  assign w_out_valid = (r_state == ST_FLUSH) || (r_fill >= c_ow_fill);
  assign w_final     = (r_state == ST_FLUSH) && (r_fill <= c_ow_fill);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_xfer      = w_out_valid && bus.out_ready;
  assign w_oversize  = bus.in_size > c_max_size;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  // Bits below fill are always zero, so the final word is padded for free.
  assign bus.out_data  = w_out_valid ? r_acc[AW-1 -: OUT_WIDTH] : '0;
  assign bus.out_last  = w_out_valid && w_final;

  always_comb begin
    bus.out_bits = '0;
    if (w_out_valid) begin
      bus.out_bits = w_final ? OBW'(r_fill) : OBW'(OUT_WIDTH);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    if (w_accept) begin
      if (!w_oversize) begin
        w_acc_nxt  = w_app_acc;
        w_fill_nxt = w_app_fill;
      end
      if (bus.in_last) begin
        w_state_nxt = ST_FLUSH;
      end
    end else if (w_xfer) begin
      if (w_final) begin
        w_acc_nxt   = '0;
        w_fill_nxt  = '0;
        w_state_nxt = ST_ACCUM;
      end else begin
        w_acc_nxt  = r_acc << OUT_WIDTH;
        w_fill_nxt = r_fill - c_ow_fill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_fill  <= '0;
      r_err   <= 1'b0;
      r_drop  <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_fill  <= w_fill_nxt;
      r_err   <= w_accept && w_oversize;
      if (w_accept && w_oversize && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
      if (w_xfer) begin
        r_words <= r_words + 16'd1;
      end
    end
  end

  assign err_oversize = r_err;
  assign drop_count   = r_drop;
  assign word_count   = r_words;

endmodule
`default_nettype wire

// File: tb/tb_ecg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecg_bitstream_packer
// Brief    : Directed self-checking bench for the ECG bitstream packer
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecg_bitstream_packer;
  import ecg_bitstream_packer_pkg::*;

  localparam int MC = 50;
  localparam int OW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_oversize;
  logic [7:0]  drop_count;
  logic [15:0] word_count;

  int vectors = 0;
  int miscompares = 0;

  ecg_bitstream_packer_if #(.MAX_CHUNK(MC), .OUT_WIDTH(OW)) bus ();

  ecg_bitstream_packer #(.MAX_CHUNK(MC), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .err_oversize (err_oversize),
    .drop_count   (drop_count),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_size   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send(input logic [MC-1:0] d, input logic [5:0] sz, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_size  = sz;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv(output logic [31:0] d, output logic [5:0] b, output logic l, output bit ok);
    d = '0; b = '0; l = 1'b0; ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.out_valid) begin
        d = bus.out_data; b = bus.out_bits; l = bus.out_last; ok = 1'b1;
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    vectors++; if (bus.out_bits !== 6'd0) begin miscompares++; $display("FAIL reset_out_bits: got %0d want 0", bus.out_bits); end
    vectors++; if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (err_oversize !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_oversize); end
    vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    vectors++; if (word_count !== 16'd0) begin miscompares++; $display("FAIL reset_words: got %0d want 0", word_count); end
  endtask

  task automatic test_pack_basic();
    logic [31:0] d; logic [5:0] b; logic l; bit ok;
    do_reset();
    send(50'hFFFFF, 6'd20, 1'b0);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_at20: got %b want 0", bus.out_valid); end
    send(50'h0, 6'd20, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_at40: got %b want 1", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_at40: got %b want 0", bus.in_ready); end
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_word_timeout: got %b want 1", ok); end
    vectors++; if (d !== 32'hFFFFF000) begin miscompares++; $display("FAIL basic_data: got %h want fffff000", d); end
    vectors++; if (b !== 6'd32) begin miscompares++; $display("FAIL basic_bits: got %0d want 32", b); end
    vectors++; if (l !== 1'b0) begin miscompares++; $display("FAIL basic_last: got %b want 0", l); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_at8: got %b want 1", bus.in_ready); end
    send(50'h0, 6'd0, 1'b1);
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || b !== 6'd8 || l !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL basic_tail: got ok=%b bits=%0d last=%b data=%h want 1/8/1/0", ok, b, l, d); end
    vectors++; if (word_count !== 16'd2) begin miscompares++; $display("FAIL basic_words: got %0d want 2", word_count); end
  endtask

  task automatic test_flush_long();
    logic [31:0] d; logic [5:0] b; logic l; bit ok;
    do_reset();
    send({32'h89ABCDEF, 18'h31234}, 6'd50, 1'b1);
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || d !== 32'h89ABCDEF || b !== 6'd32 || l !== 1'b0) begin miscompares++; $display("FAIL long_word1: got ok=%b data=%h bits=%0d last=%b want 1/89abcdef/32/0", ok, d, b, l); end
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || d !== 32'hC48D0000 || b !== 6'd18 || l !== 1'b1) begin miscompares++; $display("FAIL long_word2: got ok=%b data=%h bits=%0d last=%b want 1/c48d0000/18/1", ok, d, b, l); end
    vectors++; if (word_count !== 16'd2) begin miscompares++; $display("FAIL long_words: got %0d want 2", word_count); end
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL long_idle: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [5:0] b; logic l; bit ok;
    do_reset();
    send(50'hABCDE, 6'd20, 1'b0);
    send(50'h12345, 6'd20, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 50'h3FFFF; bus.in_size = 6'd18;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.in_ready); end
      vectors++; if (bus.out_data !== 32'hABCDE123) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want abcde123", i, bus.out_data); end
      tick();
    end
    bus.in_valid = 1'b0;
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || d !== 32'hABCDE123 || b !== 6'd32) begin miscompares++; $display("FAIL bp_word: got ok=%b data=%h bits=%0d want 1/abcde123/32", ok, d, b); end
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_after: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    send(50'h0, 6'd0, 1'b1);
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || d !== 32'h45000000 || b !== 6'd8 || l !== 1'b1) begin miscompares++; $display("FAIL bp_tail: got ok=%b data=%h bits=%0d last=%b want 1/45000000/8/1", ok, d, b, l); end
  endtask

  task automatic test_oversize();
    logic [31:0] d; logic [5:0] b; logic l; bit ok;
    do_reset();
    send(50'hFFFFF, 6'd20, 1'b0);
    send({MC{1'b1}}, 6'd51, 1'b0);
    vectors++; if (err_oversize !== 1'b1) begin miscompares++; $display("FAIL ovs_pulse: got %b want 1", err_oversize); end
    vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL ovs_drop: got %0d want 1", drop_count); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL ovs_state: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    tick();
    vectors++; if (err_oversize !== 1'b0) begin miscompares++; $display("FAIL ovs_pulse_end: got %b want 0", err_oversize); end
    // Oversize chunk still carries in_last into the flush.
    send({MC{1'b1}}, 6'd63, 1'b1);
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || d !== 32'hFFFFF000 || b !== 6'd20 || l !== 1'b1) begin miscompares++; $display("FAIL ovs_flush: got ok=%b data=%h bits=%0d last=%b want 1/fffff000/20/1", ok, d, b, l); end
    vectors++; if (drop_count !== 8'd2) begin miscompares++; $display("FAIL ovs_drop2: got %0d want 2", drop_count); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < 256; i++) send(50'h1, 6'd60, 1'b0);
    vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL sat_drop: got %0d want 255", drop_count); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL sat_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_zero_flush();
    logic [31:0] d; logic [5:0] b; logic l; bit ok;
    do_reset();
    send(50'h3FFFF, 6'd0, 1'b1);
    vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_state: got valid=%b ready=%b want 1/0", bus.out_valid, bus.in_ready); end
    recv(d, b, l, ok);
    vectors++; if (ok !== 1'b1 || d !== 32'h0 || b !== 6'd0 || l !== 1'b1) begin miscompares++; $display("FAIL zero_word: got ok=%b data=%h bits=%0d last=%b want 1/0/0/1", ok, d, b, l); end
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_back: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    vectors++; if (word_count !== 16'd1) begin miscompares++; $display("FAIL zero_words: got %0d want 1", word_count); end
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] d; logic [5:0] b; logic l; bit ok;
    int seen;
    do_reset();
    send({32'h89ABCDEF, 18'h31234}, 6'd50, 1'b1);
    recv(d, b, l, ok);
    vectors++; if (bus.out_bits !== 6'd18 || bus.out_last !== 1'b1) begin miscompares++; $display("FAIL rmf_pending: got bits=%0d last=%b want 18/1", bus.out_bits, bus.out_last); end
    bus.out_ready = 1'b1;
    rst = 1'b0;
    tick();
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rmf_state: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    vectors++; if (word_count !== 16'd0 || drop_count !== 8'd0 || err_oversize !== 1'b0) begin miscompares++; $display("FAIL rmf_counters: got words=%0d drops=%0d err=%b want 0/0/0", word_count, drop_count, err_oversize); end
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    bus.out_ready = 1'b0;
    vectors++; if (seen !== 0 || word_count !== 16'd0) begin miscompares++; $display("FAIL rmf_no_word: got valid_cycles=%0d words=%0d want 0/0", seen, word_count); end
  endtask

  initial begin
    test_reset();
    test_pack_basic();
    test_flush_long();
    test_backpressure();
    test_oversize();
    test_drop_saturate();
    test_zero_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
